// File: rtl/can_bus_pkg.sv
// -----------------------------------------------------------------------------
// can_bus_pkg
// Shared types and constants for the CAN bus line model.
//   stuck_state_t  : states of the stuck-dominant detector
//   CAN_DOMINANT   : bus level of a dominant bit (0)
//   CAN_RECESSIVE  : bus level of a recessive bit (1)
//   delay_depth()  : number of shift stages behind tap 0 for a given select width
// -----------------------------------------------------------------------------
package can_bus_pkg;

   typedef enum logic [1:0] {
      REC   = 2'd0,
      DOM   = 2'd1,
      STUCK = 2'd2
   } stuck_state_t;

   localparam logic CAN_DOMINANT  = 1'b0;
   localparam logic CAN_RECESSIVE = 1'b1;

   // A DELAY_W-bit select addresses taps 0..2**DELAY_W-1; tap 0 is the
   // input itself, so the register chain needs one stage fewer.
   function automatic int delay_depth(input int delay_w);
      return (1 << delay_w) - 1;
   endfunction

endpackage

// File: rtl/can_delay_line.sv
// -----------------------------------------------------------------------------
// can_delay_line
// Per-node receive delay: a recessive-filled shift register fed by the bus
// level, with a registered tap select.
// Ports:
//   can_clk  in   model clock
//   can_rst  in   asynchronous reset, active-high (fills chain with recessive)
//   din      in   bus level to delay (tap 0)
//   sel      in   DELAY_W  tap select, 0 = undelayed
//   dout     out  registered selected tap
// -----------------------------------------------------------------------------
module can_delay_line
   import can_bus_pkg::*;
#(
   parameter int DELAY_W = 4
) (
   input  logic               can_clk,
   input  logic               can_rst,
   input  logic               din,
   input  logic [DELAY_W-1:0] sel,
   output logic               dout
);

   localparam int DEPTH = delay_depth(DELAY_W);

   logic [DEPTH:1] sr;
   logic [DEPTH:0] taps;

   // taps[k] is din delayed by k cycles
   assign taps = {sr, din};

   always_ff @(posedge can_clk or posedge can_rst) begin
      if (can_rst) begin
         sr   <= '1;
         dout <= CAN_RECESSIVE;
      end else begin
         sr   <= taps[DEPTH-1:0];
         dout <= taps[sel];
      end
   end

endmodule

// File: rtl/can_bus_model.sv
// -----------------------------------------------------------------------------
// can_bus_model
// Wired-AND CAN line for NUM_NODES nodes with per-node receive delay,
// stuck-dominant detection and a recessive-to-dominant edge counter.
// Optional fault injection on the receive paths under `CAN_BUS_FAULT_INJ_EN.
// Ports:
//   can_clk         in   oversampled bit clock
//   can_rst         in   asynchronous reset, active-high
//   can_tx          in   NUM_NODES  per-node transmit, 0 = dominant
//   node_en         in   NUM_NODES  1 = node drives the line
//   delay_cfg       in   NUM_NODES*DELAY_W  per-node extra rx delay
//   stuck_clr       in   clears the sticky stuck_dominant flag
//   fault_node      in   node index for fault injection
//   fault_strobe    in   one-cycle fault request
//   can_rx          out  NUM_NODES  per-node delayed bus level
//   bus_level       out  registered wired-AND level
//   stuck_dominant  out  sticky stuck-dominant flag
//   edge_cnt        out  EDGE_CNT_W  count of 1->0 transitions of bus_level
//   stuck_state     out  detector FSM state (debug)
// -----------------------------------------------------------------------------
module can_bus_model
   import can_bus_pkg::*;
#(
   parameter int NUM_NODES   = 2,
   parameter int DELAY_W     = 4,
   parameter int STUCK_LIMIT = 1024,
   parameter int EDGE_CNT_W  = 16
) (
   input  logic                          can_clk,
   input  logic                          can_rst,
   input  logic [NUM_NODES-1:0]          can_tx,
   input  logic [NUM_NODES-1:0]          node_en,
   input  logic [NUM_NODES*DELAY_W-1:0]  delay_cfg,
   input  logic                          stuck_clr,
   input  logic [$clog2(NUM_NODES)-1:0]  fault_node,
   input  logic                          fault_strobe,
   output logic [NUM_NODES-1:0]          can_rx,
   output logic                          bus_level,
   output logic                          stuck_dominant,
   output logic [EDGE_CNT_W-1:0]         edge_cnt,
   output logic [1:0]                    stuck_state
);

   localparam int CNT_W = $clog2(STUCK_LIMIT + 1);

   localparam logic [1:0] S_REC   = REC;
   localparam logic [1:0] S_DOM   = DOM;
   localparam logic [1:0] S_STUCK = STUCK;

   logic                 bus_raw;
   logic [NUM_NODES-1:0] rx_delayed;
   logic [1:0]           state_q;
   logic [CNT_W-1:0]     dom_cnt;
   logic                 stuck_set;

   // Disabled nodes float recessive; no enabled node leaves the line recessive.
   assign bus_raw = &(can_tx | ~node_en);

   always_ff @(posedge can_clk or posedge can_rst) begin
      if (can_rst) begin
         bus_level <= CAN_RECESSIVE;
         edge_cnt  <= '0;
      end else begin
         bus_level <= bus_raw;
         if (bus_level == CAN_RECESSIVE && bus_raw == CAN_DOMINANT)
            edge_cnt <= edge_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
      can_delay_line #(.DELAY_W(DELAY_W)) u_delay (
         .can_clk (can_clk),
         .can_rst (can_rst),
         .din     (bus_level),
         .sel     (delay_cfg[g*DELAY_W +: DELAY_W]),
         .dout    (rx_delayed[g])
      );
   end

   // The flag is set on the DOM->STUCK step, and re-armed in STUCK once a
   // clear has dropped it while the line is still dominant. Set beats clear.
   assign stuck_set =
      (state_q == S_DOM   && bus_level == CAN_DOMINANT &&
       dom_cnt == CNT_W'(STUCK_LIMIT - 1)) ||
      (state_q == S_STUCK && bus_level == CAN_DOMINANT && !stuck_dominant);

   always_ff @(posedge can_clk or posedge can_rst) begin
      if (can_rst) begin
         state_q        <= S_REC;
         dom_cnt        <= '0;
         stuck_dominant <= 1'b0;
      end else begin
         case (state_q)
            S_REC: begin
               if (bus_level == CAN_DOMINANT) begin
                  state_q <= S_DOM;
                  dom_cnt <= CNT_W'(1);
               end else begin
                  dom_cnt <= '0;
               end
            end
            S_DOM: begin
               if (bus_level == CAN_RECESSIVE) begin
                  state_q <= S_REC;
                  dom_cnt <= '0;
               end else begin
                  if (dom_cnt == CNT_W'(STUCK_LIMIT - 1))
                     state_q <= S_STUCK;
                  if (dom_cnt < CNT_W'(STUCK_LIMIT))
                     dom_cnt <= dom_cnt + 1'b1;
               end
            end
            S_STUCK: begin
               if (bus_level == CAN_RECESSIVE) begin
                  state_q <= S_REC;
                  dom_cnt <= '0;
               end
            end
            default: begin
               state_q <= S_REC;
               dom_cnt <= '0;
            end
         endcase

         if (stuck_set)
            stuck_dominant <= 1'b1;
         else if (stuck_clr)
            stuck_dominant <= 1'b0;
      end
   end

   assign stuck_state = state_q;

`ifdef CAN_BUS_FAULT_INJ_EN
   // The inversion lives only on the output; bus_level and the delay
   // chains never see it.
   logic [NUM_NODES-1:0] fault_mask;

   always_ff @(posedge can_clk or posedge can_rst) begin
      if (can_rst) begin
         fault_mask <= '0;
      end else begin
         fault_mask <= '0;
         if (fault_strobe && (int'(fault_node) < NUM_NODES))
            fault_mask[fault_node] <= 1'b1;
      end
   end

   assign can_rx = rx_delayed ^ fault_mask;
`else
   logic unused_fault;
   assign unused_fault = ^{fault_node, fault_strobe};
   assign can_rx       = rx_delayed;
`endif

endmodule

// File: tb/tb_can_bus_model.sv
// -----------------------------------------------------------------------------
// tb_can_bus_model
// Bench for can_bus_model with NUM_NODES=4, DELAY_W=4, STUCK_LIMIT=16,
// EDGE_CNT_W=4. The driver pushes the expected post-edge outputs for every
// cycle into exp_q; the monitor pops one entry after each rising edge.
// The reference model keeps the whole post-reset bus history and derives
// rx taps, edge counts and the stuck flag from run lengths of that history.
// -----------------------------------------------------------------------------
module tb_can_bus_model;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int SL = 16;
   localparam int EW = 4;
   localparam int NW = 2;
   localparam int W  = N + 2 + EW;

   logic            can_clk = 1'b0;
   logic            can_rst = 1'b1;
   logic [N-1:0]    can_tx = '1;
   logic [N-1:0]    node_en = '1;
   logic [N*DW-1:0] delay_cfg = '0;
   logic            stuck_clr = 1'b0;
   logic [NW-1:0]   fault_node = '0;
   logic            fault_strobe = 1'b0;
   logic [N-1:0]    can_rx;
   logic            bus_level;
   logic            stuck_dominant;
   logic [EW-1:0]   edge_cnt;
   logic [1:0]      dut_state;

   can_bus_model #(
      .NUM_NODES   (N),
      .DELAY_W     (DW),
      .STUCK_LIMIT (SL),
      .EDGE_CNT_W  (EW)
   ) dut (
      .can_clk        (can_clk),
      .can_rst        (can_rst),
      .can_tx         (can_tx),
      .node_en        (node_en),
      .delay_cfg      (delay_cfg),
      .stuck_clr      (stuck_clr),
      .fault_node     (fault_node),
      .fault_strobe   (fault_strobe),
      .can_rx         (can_rx),
      .bus_level      (bus_level),
      .stuck_dominant (stuck_dominant),
      .edge_cnt       (edge_cnt),
      .stuck_state    (dut_state)
   );

   // ---------------- clock ----------------
   always #5 can_clk = ~can_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   bit           mon_go  = 1'b0;

   // reference model state
   logic lvl_hist[$];   // bus level after each post-reset edge
   int   run_len = 0;   // trailing dominant run in lvl_hist
   int   ecnt    = 0;
   logic flag    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic rst, input logic [N-1:0] tx, input logic [N-1:0] en,
                       input logic [N*DW-1:0] cfg, input logic clr,
                       input logic [NW-1:0] fn, input logic fs);
      logic [N-1:0] rx;
      logic         raw;
      logic         prev;
      int           n;
      int           idx;
      @(negedge can_clk);
      can_rst      = rst;
      can_tx       = tx;
      node_en      = en;
      delay_cfg    = cfg;
      stuck_clr    = clr;
      fault_node   = fn;
      fault_strobe = fs;
      if (rst) begin
         lvl_hist.delete();
         run_len = 0;
         ecnt    = 0;
         flag    = 1'b0;
         exp_q.push_back({{N{1'b1}}, 1'b1, 1'b0, {EW{1'b0}}});
      end else begin
         raw = 1'b1;
         for (int i = 0; i < N; i++)
            if (en[i] && !tx[i]) raw = 1'b0;
         n = lvl_hist.size();
         for (int i = 0; i < N; i++) begin
            idx   = n - 1 - int'(cfg[i*DW +: DW]);
            rx[i] = (idx < 0) ? 1'b1 : lvl_hist[idx];
         end
`ifdef CAN_BUS_FAULT_INJ_EN
         if (fs && int'(fn) < N) rx[fn] = ~rx[fn];
`endif
         prev = (n > 0) ? lvl_hist[n-1] : 1'b1;
         if (prev && !raw) ecnt = (ecnt + 1) % (1 << EW);
         if (run_len == SL)            flag = 1'b1;
         else if (run_len > SL && !flag) flag = 1'b1;
         else if (clr)                 flag = 1'b0;
         lvl_hist.push_back(raw);
         run_len = raw ? 0 : run_len + 1;
         exp_q.push_back({rx, raw, flag, EW'(ecnt)});
      end
      mon_go = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [W-1:0] e;
      wait (mon_go);
      forever begin
         @(posedge can_clk);
         #1;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL underflow at %0t: output with no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            check("can_rx",         32'(can_rx),         32'(e[W-1 -: N]));
            check("bus_level",      32'(bus_level),      32'(e[EW+1]));
            check("stuck_dominant", 32'(stuck_dominant), 32'(e[EW]));
            check("edge_cnt",       32'(edge_cnt),       32'(e[EW-1:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [N*DW-1:0] cfg0;
      logic [N*DW-1:0] cfg;
      logic [N-1:0]    en;
      logic [N-1:0]    tx;
      int              bnode;
      int              blen;
      int              guard;

      cfg0 = {4'd3, 4'd0, 4'd7, 4'd1};

      // reset and idle
      repeat (3) step(1'b1, '1, '1, cfg0, 1'b0, '0, 1'b0);
      repeat (5) step(1'b0, '1, '1, cfg0, 1'b0, '0, 1'b0);

      // node 2 dominant for 5 cycles, watch each rx delay
      repeat (5)  step(1'b0, 4'b1011, '1, cfg0, 1'b0, '0, 1'b0);
      repeat (12) step(1'b0, '1,      '1, cfg0, 1'b0, '0, 1'b0);

      // node 2 disabled while driving dominant
      repeat (5) step(1'b0, 4'b1011, 4'b1011, cfg0, 1'b0, '0, 1'b0);
      repeat (3) step(1'b0, '1,      '1,      cfg0, 1'b0, '0, 1'b0);

      // stuck-dominant, release, then clear
      repeat (20) step(1'b0, 4'b1110, '1, cfg0, 1'b0, '0, 1'b0);
      repeat (3)  step(1'b0, '1,      '1, cfg0, 1'b0, '0, 1'b0);
      step(1'b0, '1, '1, cfg0, 1'b1, '0, 1'b0);
      repeat (3)  step(1'b0, '1,      '1, cfg0, 1'b0, '0, 1'b0);

      // clear while still stuck: flag drops for one cycle, then returns
      repeat (18) step(1'b0, 4'b1110, '1, cfg0, 1'b0, '0, 1'b0);
      step(1'b0, 4'b1110, '1, cfg0, 1'b1, '0, 1'b0);
      repeat (3)  step(1'b0, 4'b1110, '1, cfg0, 1'b0, '0, 1'b0);
      repeat (3)  step(1'b0, '1,      '1, cfg0, 1'b0, '0, 1'b0);

      // reset mid-operation with dominant history in the delay lines
      repeat (6) step(1'b0, 4'b1110, '1, cfg0, 1'b0, '0, 1'b0);
      repeat (2) step(1'b1, 4'b1110, '1, cfg0, 1'b0, '0, 1'b0);

      // 17 dominant pulses: edge counter wraps to 1
      repeat (17) begin
         step(1'b0, 4'b1101, '1, cfg0, 1'b0, '0, 1'b0);
         step(1'b0, '1,      '1, cfg0, 1'b0, '0, 1'b0);
      end
      repeat (10) step(1'b0, '1, '1, cfg0, 1'b0, '0, 1'b0);

      // fault strobe on node 1 while recessive
      step(1'b0, '1, '1, cfg0, 1'b0, 2'd1, 1'b1);
      repeat (3) step(1'b0, '1, '1, cfg0, 1'b0, '0, 1'b0);

      // randomized chunks: one long burst per chunk plus sparse random traffic
      for (int c = 0; c < 16; c++) begin
         cfg   = N*DW'($urandom);
         en    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         bnode = $urandom_range(0, N-1);
         blen  = $urandom_range(4, 22);
         for (int k = 0; k < 25; k++) begin
            tx = '1;
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 4) == 0) tx[i] = 1'b0;
            if (k < blen) tx[bnode] = 1'b0;
            if ($urandom_range(0, 19) == 0) cfg = N*DW'($urandom);
            step(($urandom_range(0, 199) == 0), tx, en, cfg,
                 ($urandom_range(0, 15) == 0), NW'($urandom),
                 ($urandom_range(0, 7) == 0));
         end
      end
      repeat (4) step(1'b0, '1, '1, cfg0, 1'b0, '0, 1'b0);

      // drain
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge can_clk);
         #2;
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
